// File: rtl/fetch_seq_pkg.sv
// Shared types and the per-state output decode for the instruction-fetch sequencer.
//   fetch_state_t : sequencer state encoding
//   fetch_ctrl_t  : control-bus strobes driven by the sequencer
//   fetch_decode  : state -> control strobes
//   is_fetch_phase: true for the timed F_* states
package fetch_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    F_ADDR = 3'd1,
    F_READ = 3'd2,
    F_LOAD = 3'd3,
    F_INC  = 3'd4,
    F_PCWB = 3'd5,
    EXEC   = 3'd6,
    HALT   = 3'd7
  } fetch_state_t;

  typedef struct packed {
    logic sel_pc;
    logic mem_rd;
    logic ld_inst;
    logic ld_inc;
    logic sel_inc;
    logic ld_pc;
    logic exec_go;
  } fetch_ctrl_t;

  // Control strobes for a state; exec_go only in the first EXEC cycle.
  function automatic fetch_ctrl_t fetch_decode(input fetch_state_t st,
                                               input logic first_exec);
    fetch_ctrl_t c;
    c = '0;
    case (st)
      F_ADDR: begin
        c.sel_pc = 1'b1;
      end
      F_READ: begin
        c.sel_pc = 1'b1;
        c.mem_rd = 1'b1;
      end
      F_LOAD: begin
        c.sel_pc  = 1'b1;
        c.mem_rd  = 1'b1;
        c.ld_inst = 1'b1;
      end
      F_INC: begin
        c.sel_pc = 1'b1;
        c.ld_inc = 1'b1;
      end
      F_PCWB: begin
        c.sel_inc = 1'b1;
        c.ld_pc   = 1'b1;
      end
      EXEC: begin
        c.exec_go = first_exec;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // States whose duration is governed by the phase timer.
  function automatic logic is_fetch_phase(input fetch_state_t st);
    return (st == F_ADDR) || (st == F_READ) || (st == F_LOAD) ||
           (st == F_INC)  || (st == F_PCWB);
  endfunction

endpackage

// File: rtl/fetch_sequencer_phase_timer.sv
// Stretches each fetch phase to PHASE_CYCLES clocks.
//   clock, reset : clock and async active-high reset
//   clear        : restart the count (state change)
//   enable       : count this cycle (in a timed phase)
//   phase_done   : high in the last cycle of the current phase
module phase_timer #(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic phase_done
);

  localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Last cycle of a phase is reached when the count hits PHASE_CYCLES-1.
  assign phase_done = enable && (cnt == LAST);

  // Counts 0..PHASE_CYCLES-1, back to 0 on any state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || phase_done) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-cycle controller around the instruction register: PC to address bus,
// memory read, ldINST, PC increment and write-back, then hand-off to execute.
//   clock, reset            : clock and async active-high reset
//   start                   : begin fetching from IDLE or HALT
//   halt_req                : stop at the next instruction boundary
//   exec_done               : execute logic finished the current instruction
//   sel_pc..exec_go         : registered control-bus strobes
//   busy, halted            : registered status
//   fetch_count             : instructions loaded, wraps
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             exec_done,
  output logic             sel_pc,
  output logic             mem_rd,
  output logic             ld_inst,
  output logic             ld_inc,
  output logic             sel_inc,
  output logic             ld_pc,
  output logic             exec_go,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t state;
  fetch_state_t state_n;
  fetch_ctrl_t  ctrl_q;
  logic         halt_pending;
  logic         phase_done;
  logic         in_phase;
  logic         state_busy;

  assign in_phase   = is_fetch_phase(state);
  assign state_busy = (state != IDLE) && (state != HALT);

  phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_n != state),
    .enable     (in_phase),
    .phase_done (phase_done)
  );

  // Next-state selection.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start)      state_n = F_ADDR;
      HALT:   if (start)      state_n = F_ADDR;
      F_ADDR: if (phase_done) state_n = F_READ;
      F_READ: if (phase_done) state_n = F_LOAD;
      F_LOAD: if (phase_done) state_n = F_INC;
      F_INC:  if (phase_done) state_n = F_PCWB;
      F_PCWB: if (phase_done) state_n = EXEC;
      // A halt request arriving with exec_done still counts for this boundary.
      EXEC: begin
        if (exec_done) begin
          state_n = (halt_pending || halt_req) ? HALT : F_ADDR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, halt flag, counter and registered decodes of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ctrl_q       <= '0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      halt_pending <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state  <= state_n;
      ctrl_q <= fetch_decode(state_n, (state_n == EXEC) && (state != EXEC));
      busy   <= (state_n != IDLE) && (state_n != HALT);
      halted <= (state_n == HALT);

      if ((state == HALT) && start) begin
        halt_pending <= 1'b0;
      end else if (state_busy && halt_req) begin
        halt_pending <= 1'b1;
      end

      if ((state == F_LOAD) && (state_n == F_INC)) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

  assign sel_pc  = ctrl_q.sel_pc;
  assign mem_rd  = ctrl_q.mem_rd;
  assign ld_inst = ctrl_q.ld_inst;
  assign ld_inc  = ctrl_q.ld_inc;
  assign sel_inc = ctrl_q.sel_inc;
  assign ld_pc   = ctrl_q.ld_pc;
  assign exec_go = ctrl_q.exec_go;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: instance a (P=2, CNT_W=16) for sequencing, halt and reset;
// instance b (P=1, CNT_W=4) for back-to-back operation and counter wrap.
module tb_fetch_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic start_a, halt_req_a, exec_done_a;
  logic start_b, halt_req_b, exec_done_b;

  logic sel_pc_a, mem_rd_a, ld_inst_a, ld_inc_a, sel_inc_a, ld_pc_a, exec_go_a;
  logic busy_a, halted_a;
  logic [15:0] fetch_a;
  logic sel_pc_b, mem_rd_b, ld_inst_b, ld_inc_b, sel_inc_b, ld_pc_b, exec_go_b;
  logic busy_b, halted_b;
  logic [3:0] fetch_b;

  logic [6:0] ctrl_a, ctrl_b;
  assign ctrl_a = {sel_pc_a, mem_rd_a, ld_inst_a, ld_inc_a, sel_inc_a, ld_pc_a, exec_go_a};
  assign ctrl_b = {sel_pc_b, mem_rd_b, ld_inst_b, ld_inc_b, sel_inc_b, ld_pc_b, exec_go_b};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(.PHASE_CYCLES(2), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .halt_req(halt_req_a),
    .exec_done(exec_done_a), .sel_pc(sel_pc_a), .mem_rd(mem_rd_a),
    .ld_inst(ld_inst_a), .ld_inc(ld_inc_a), .sel_inc(sel_inc_a), .ld_pc(ld_pc_a),
    .exec_go(exec_go_a), .busy(busy_a), .halted(halted_a), .fetch_count(fetch_a)
  );

  fetch_sequencer #(.PHASE_CYCLES(1), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .halt_req(halt_req_b),
    .exec_done(exec_done_b), .sel_pc(sel_pc_b), .mem_rd(mem_rd_b),
    .ld_inst(ld_inst_b), .ld_inc(ld_inc_b), .sel_inc(sel_inc_b), .ld_pc(ld_pc_b),
    .exec_go(exec_go_b), .busy(busy_b), .halted(halted_b), .fetch_count(fetch_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  // start sampled at the next edge (edge 0); returns in cycle 1.
  task automatic kick_a();
    start_a = 1'b1;
    cyc = -1;
    step();
    start_a = 1'b0;
    cyc = 1;
  endtask

  initial begin
    logic [6:0] e;
    reset = 1'b1;
    start_a = 0; halt_req_a = 0; exec_done_a = 0;
    start_b = 0; halt_req_b = 0; exec_done_b = 0;

    // Reset state
    step(); step();
    chk("rst_ctrl_a", 32'(ctrl_a), 32'h0);
    chk("rst_status_a", {30'd0, busy_a, halted_a}, 32'h0);
    chk("rst_count_a", 32'(fetch_a), 32'h0);
    chk("rst_ctrl_b", 32'(ctrl_b), 32'h0);
    #2 reset = 1'b0;
    step();
    chk("idle_status_a", {30'd0, busy_a, halted_a}, 32'h0);

    // Single instruction, exec_done tied high
    exec_done_a = 1'b1;
    kick_a();
    for (int c = 1; c <= 12; c++) begin
      e = {(c <= 8) || (c == 12), (c >= 3) && (c <= 6), (c >= 5) && (c <= 6),
           (c >= 7) && (c <= 8), (c >= 9) && (c <= 10), (c >= 9) && (c <= 10),
           c == 11};
      chk($sformatf("single_ctrl_c%0d", c), 32'(ctrl_a), 32'(e));
      chk($sformatf("single_count_c%0d", c), 32'(fetch_a), (c >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("single_busy_c%0d", c), {31'd0, busy_a}, 32'd1);
      if (c < 12) step();
    end
    // Halt requested in F_ADDR of the second instruction: it still completes.
    halt_req_a = 1'b1;
    step();
    halt_req_a = 1'b0;
    step_to(22);
    chk("second_exec_go", 32'(ctrl_a), 32'h01);
    step();
    chk("second_halted", {30'd0, busy_a, halted_a}, 32'h1);
    chk("second_count", 32'(fetch_a), 32'd2);
    exec_done_a = 1'b0;

    // Reset mid-fetch (resume from HALT, reset in cycle 6)
    kick_a();
    step_to(6);
    chk("rmf_in_load", 32'(ctrl_a), 32'h70);
    #2 reset = 1'b1;
    #1;
    chk("rmf_async_ctrl", 32'(ctrl_a), 32'h0);
    chk("rmf_async_count", 32'(fetch_a), 32'h0);
    #2 reset = 1'b0;
    step();
    chk("rmf_idle_status", {30'd0, busy_a, halted_a}, 32'h0);
    chk("rmf_idle_ctrl", 32'(ctrl_a), 32'h0);
    chk("rmf_idle_count", 32'(fetch_a), 32'h0);

    // Halt mid-fetch: halt_req in F_READ, exec_done 3 cycles after exec_go
    kick_a();
    step_to(3);
    chk("hmf_in_read", 32'(ctrl_a), 32'h60);
    halt_req_a = 1'b1;
    step();
    halt_req_a = 1'b0;
    step_to(11);
    chk("hmf_exec_go", 32'(ctrl_a), 32'h01);
    step();
    chk("hmf_exec_hold", {29'd0, exec_go_a, busy_a, halted_a}, 32'h2);
    step_to(14);
    chk("hmf_exec_wait", {29'd0, exec_go_a, busy_a, halted_a}, 32'h2);
    exec_done_a = 1'b1;
    step();
    exec_done_a = 1'b0;
    chk("hmf_halted", {30'd0, busy_a, halted_a}, 32'h1);
    chk("hmf_count", 32'(fetch_a), 32'd1);
    step();
    chk("hmf_stays_halted", {30'd0, busy_a, halted_a}, 32'h1);

    // Resume; halt_pending must be cleared so the next boundary continues.
    kick_a();
    chk("resume_addr", {23'd0, ctrl_a, busy_a, halted_a}, {23'd0, 7'h40, 2'b10});
    step_to(7);
    chk("resume_count", 32'(fetch_a), 32'd2);
    step_to(11);
    chk("resume_exec_go", 32'(ctrl_a), 32'h01);
    exec_done_a = 1'b1;
    step();
    exec_done_a = 1'b0;
    chk("resume_no_halt", {23'd0, ctrl_a, busy_a, halted_a}, {23'd0, 7'h40, 2'b10});

    // Halt request on the same cycle as exec_done
    step_to(22);
    chk("hed_exec_go", 32'(ctrl_a), 32'h01);
    step();
    chk("hed_exec_hold", {29'd0, exec_go_a, busy_a, halted_a}, 32'h2);
    halt_req_a = 1'b1;
    exec_done_a = 1'b1;
    step();
    halt_req_a = 1'b0;
    exec_done_a = 1'b0;
    chk("hed_halted", {30'd0, busy_a, halted_a}, 32'h1);
    chk("hed_count", 32'(fetch_a), 32'd3);

    // Ignored inputs: halt_req/exec_done in IDLE, exec_done during fetch
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    halt_req_a = 1'b1;
    exec_done_a = 1'b1;
    step(); step();
    chk("ign_idle_status", {30'd0, busy_a, halted_a}, 32'h0);
    chk("ign_idle_ctrl", 32'(ctrl_a), 32'h0);
    start_a = 1'b1;
    cyc = -1;
    step();
    start_a = 1'b0;
    halt_req_a = 1'b0;
    cyc = 1;
    chk("ign_start", {23'd0, ctrl_a, busy_a, halted_a}, {23'd0, 7'h40, 2'b10});
    step_to(3);
    chk("ign_read_timing", 32'(ctrl_a), 32'h60);
    step_to(11);
    chk("ign_exec_go", 32'(ctrl_a), 32'h01);
    step();
    chk("ign_no_halt", {23'd0, ctrl_a, busy_a, halted_a}, {23'd0, 7'h40, 2'b10});
    exec_done_a = 1'b0;

    // Counter wrap on instance b: P=1, CNT_W=4, back-to-back
    exec_done_b = 1'b1;
    start_b = 1'b1;
    cyc = -1;
    step();
    start_b = 1'b0;
    cyc = 1;
    for (int c = 1; c <= 102; c++) begin
      case (c)
        1:   chk("wrap_addr_c1", 32'(ctrl_b), 32'h40);
        3: begin
          chk("wrap_load_c3", 32'(ctrl_b), 32'h70);
          chk("wrap_count_c3", 32'(fetch_b), 32'd0);
        end
        4:   chk("wrap_count_c4", 32'(fetch_b), 32'd1);
        5:   chk("wrap_pcwb_c5", 32'(ctrl_b), 32'h06);
        6:   chk("wrap_exec_c6", 32'(ctrl_b), 32'h01);
        7:   chk("wrap_addr_c7", 32'(ctrl_b), 32'h40);
        12:  chk("wrap_exec_c12", 32'(ctrl_b), 32'h01);
        88:  chk("wrap_count_c88", 32'(fetch_b), 32'd15);
        93:  chk("wrap_count_c93", 32'(fetch_b), 32'd15);
        94:  chk("wrap_count_c94", 32'(fetch_b), 32'd0);
        100: chk("wrap_count_c100", 32'(fetch_b), 32'd1);
        102: chk("wrap_exec_c102", 32'(ctrl_b), 32'h01);
        default: ;
      endcase
      if (c < 102) step();
    end
    chk("wrap_busy", {30'd0, busy_b, halted_b}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
